// File: rtl/hazard_if.sv
// hazard_if: ID/EX/MEM/WB hazard inputs and the pipeline stall/flush/status outputs
interface hazard_if;
  logic [4:0] rs1_d, rs2_d, rd_e, rd_m, rd_w;
  logic rs1_used_d, rs2_used_d, regwrite_e, regwrite_m, regwrite_w;
  logic memread_e, redirect_e, mem_req_m, mem_ready_m;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  modport master (
    output rs1_d, rs2_d, rd_e, rd_m, rd_w, rs1_used_d, rs2_used_d, regwrite_e, regwrite_m, regwrite_w,
           memread_e, redirect_e, mem_req_m, mem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout, stall_cnt, flush_cnt
  );
  modport slave (
    input  rs1_d, rs2_d, rd_e, rd_m, rd_w, rs1_used_d, rs2_used_d, regwrite_e, regwrite_m, regwrite_w,
           memread_e, redirect_e, mem_req_m, mem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush control with data-memory timeout watchdog and perf counters.
// Define FORWARDING_EN when a full bypass network exists, so only load-use needs a stall.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  hazard_if.slave hz
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2;
  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic [15:0] s_cnt, f_cnt;
  logic mem_stall, err, hit_e, hit_m, hit_w, hazard;
  logic [6:0] ctrl;
  function automatic logic src_hit(input logic u1, input logic [4:0] r1, input logic u2,
                                   input logic [4:0] r2, input logic wr, input logic [4:0] rd);
    return wr && rd != 5'd0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction
  assign hit_e = src_hit(hz.rs1_used_d, hz.rs1_d, hz.rs2_used_d, hz.rs2_d, hz.regwrite_e, hz.rd_e);
  assign hit_m = src_hit(hz.rs1_used_d, hz.rs1_d, hz.rs2_used_d, hz.rs2_d, hz.regwrite_m, hz.rd_m);
  assign hit_w = src_hit(hz.rs1_used_d, hz.rs1_d, hz.rs2_used_d, hz.rs2_d, hz.regwrite_w, hz.rd_w);
`ifdef FORWARDING_EN
  assign hazard = hz.memread_e && hit_e;
`else
  assign hazard = hit_e || hit_m || hit_w;
`endif
  assign mem_stall = hz.mem_req_m && !hz.mem_ready_m;
  assign err = state == ERROR;
  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}; a held EX keeps redirect_e until the stall drops
  assign ctrl = reset     ? 7'b0000111 :
                err       ? 7'b1111000 :
                mem_stall ? 7'b1111001 :
                hz.redirect_e ? 7'b0000110 :
                hazard    ? 7'b1100010 : 7'b0000000;
  assign {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w} = ctrl;
  assign hz.mem_timeout = err && !reset;
  assign hz.stall_cnt = s_cnt;
  assign hz.flush_cnt = f_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= 8'd0;
      s_cnt <= 16'd0;
      f_cnt <= 16'd0;
    end else begin
      if (ctrl[6] && s_cnt != 16'hFFFF) s_cnt <= s_cnt + 16'd1;
      if (ctrl[2] && f_cnt != 16'hFFFF) f_cnt <= f_cnt + 16'd1;
      case (state)
        RUN: if (mem_stall) begin
          state <= MEM_WAIT;
          wait_cnt <= 8'd1;
        end
        MEM_WAIT: if (!mem_stall) begin
          state <= RUN;
          wait_cnt <= 8'd0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) state <= ERROR;
        else wait_cnt <= wait_cnt + 8'd1;
        ERROR: state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, hand-written corner sequences and a random run against a rule-level model.
module tb_hazard_ctrl;
  localparam int MT = 4;
`ifdef FORWARDING_EN
  localparam logic [6:0] EXT = 7'b0000000;
`else
  localparam logic [6:0] EXT = 7'b1100010;
`endif
  typedef struct {
    logic [4:0] rs1, rs2, rde, rdm, rdw;
    logic [8:0] fl;
    logic [6:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  hazard_if hz();
  hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (.clk(clk), .reset(reset), .hz(hz));
  logic [6:0] ctrl;
  assign ctrl = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w};
  int errors = 0, checks = 0;
  int m_run = 0, m_sc = 0, m_fc = 0;
  bit m_err = 0;
  vec_t vecs[13];
  initial forever #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic vec_t mk(input logic [4:0] rs1, rs2, rde, rdm, rdw, input logic [8:0] fl, input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.fl = fl; v.exp = exp;
    return v;
  endfunction
  function automatic bit model_hazard();
    logic [4:0] rd [3];
    bit wr [3];
    bit hit = 0;
    rd = '{hz.rd_e, hz.rd_m, hz.rd_w};
    wr = '{hz.regwrite_e, hz.regwrite_m, hz.regwrite_w};
    for (int i = 0; i < 3; i++) begin
`ifdef FORWARDING_EN
      if (i > 0 || !hz.memread_e) continue;
`endif
      if (wr[i] && rd[i] != 5'd0 && ((hz.rs1_used_d && hz.rs1_d == rd[i]) || (hz.rs2_used_d && hz.rs2_d == rd[i])))
        hit = 1;
    end
    return hit;
  endfunction
  function automatic logic [6:0] model_ctrl();
    if (reset) return 7'b0000111;
    if (m_err) return 7'b1111000;
    if (hz.mem_req_m && !hz.mem_ready_m) return 7'b1111001;
    if (hz.redirect_e) return 7'b0000110;
    if (model_hazard()) return 7'b1100010;
    return 7'b0000000;
  endfunction
  function automatic void model_update();
    logic [6:0] c;
    if (reset) begin
      m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
      return;
    end
    c = model_ctrl();
    if (c[6] && m_sc < 65535) m_sc++;
    if (c[2] && m_fc < 65535) m_fc++;
    if (!m_err) begin
      if (hz.mem_req_m && !hz.mem_ready_m) begin
        m_run++;
        if (m_run > MT) m_err = 1;
      end else m_run = 0;
    end
  endfunction
  task automatic set_in(input vec_t v);
    hz.rs1_d = v.rs1; hz.rs2_d = v.rs2; hz.rd_e = v.rde; hz.rd_m = v.rdm; hz.rd_w = v.rdw;
    {hz.rs1_used_d, hz.rs2_used_d, hz.regwrite_e, hz.regwrite_m, hz.regwrite_w,
     hz.memread_e, hz.redirect_e, hz.mem_req_m, hz.mem_ready_m} = v.fl;
  endtask
  task automatic idle();
    set_in(mk(0, 0, 0, 0, 0, 9'b0, 7'b0));
  endtask
  task automatic look();
    #1;
    chk("model_ctrl", 32'(ctrl), 32'(model_ctrl()));
    chk("model_timeout", 32'(hz.mem_timeout), 32'(m_err && !reset));
    chk("model_stall_cnt", 32'(hz.stall_cnt), 32'(m_sc));
    chk("model_flush_cnt", 32'(hz.flush_cnt), 32'(m_fc));
  endtask
  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_seq();
    reset = 1'b1;
    idle();
    look();
    chk("rst_ctrl", 32'(ctrl), 32'(7'b0000111));
    chk("rst_timeout", 32'(hz.mem_timeout), 0);
    tick();
    reset = 1'b0;
    look();
    chk("rst_stall_cnt", 32'(hz.stall_cnt), 0);
    chk("rst_flush_cnt", 32'(hz.flush_cnt), 0);
    chk("rst_idle_ctrl", 32'(ctrl), 0);
  endtask
  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 9'b000000000, 7'b0000000);
    vecs[1]  = mk(5, 0, 5, 0, 0, 9'b101001000, 7'b1100010);
    vecs[2]  = mk(0, 0, 0, 0, 0, 9'b101001000, 7'b0000000);
    vecs[3]  = mk(5, 0, 5, 0, 0, 9'b001001000, 7'b0000000);
    vecs[4]  = mk(5, 0, 5, 0, 0, 9'b100001000, 7'b0000000);
    vecs[5]  = mk(0, 7, 0, 7, 0, 9'b010100000, EXT);
    vecs[6]  = mk(9, 0, 0, 0, 9, 9'b100010000, EXT);
    vecs[7]  = mk(5, 0, 5, 0, 0, 9'b101001100, 7'b0000110);
    vecs[8]  = mk(5, 0, 5, 0, 0, 9'b101001110, 7'b1111001);
    vecs[9]  = mk(0, 0, 0, 0, 0, 9'b000000011, 7'b0000000);
    vecs[10] = mk(3, 0, 3, 0, 0, 9'b101000000, EXT);
    vecs[11] = mk(0, 12, 12, 0, 0, 9'b011001000, 7'b1100010);
    vecs[12] = mk(0, 0, 0, 0, 0, 9'b010100000, 7'b0000000);
    idle();
    tick();
    reset_seq();
    foreach (vecs[i]) begin
      set_in(vecs[i]);
      look();
      chk($sformatf("vec%0d", i), 32'(ctrl), 32'(vecs[i].exp));
      tick();
    end
    // load-use: one stall cycle, counted once
    reset_seq();
    set_in(vecs[1]);
    look();
    chk("lu_ctrl", 32'(ctrl), 32'(7'b1100010));
    tick();
    idle();
    look();
    chk("lu_ctrl_after", 32'(ctrl), 0);
    chk("lu_stall_cnt", 32'(hz.stall_cnt), 1);
    tick();
    // three wait cycles, release, then a full timeout
    reset_seq();
    hz.mem_req_m = 1'b1;
    for (int c = 0; c < 3; c++) begin
      look();
      chk("wait_ctrl", 32'(ctrl), 32'(7'b1111001));
      tick();
    end
    hz.mem_ready_m = 1'b1;
    look();
    chk("wait_release", 32'(ctrl), 0);
    tick();
    hz.mem_ready_m = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      look();
      chk("to_flag", 32'(hz.mem_timeout), 32'(c == 6));
      chk("to_ctrl", 32'(ctrl), c == 6 ? 32'(7'b1111000) : 32'(7'b1111001));
      tick();
    end
    hz.mem_req_m = 1'b0;
    look();
    chk("to_sticky", 32'(hz.mem_timeout), 1);
    chk("to_sticky_ctrl", 32'(ctrl), 32'(7'b1111000));
    chk("to_stall_cnt", 32'(hz.stall_cnt), 9);
    tick();
    reset_seq();
    // redirect held behind a memory stall
    hz.redirect_e = 1'b1;
    hz.mem_req_m = 1'b1;
    for (int c = 0; c < 2; c++) begin
      look();
      chk("defer_ctrl", 32'(ctrl), 32'(7'b1111001));
      tick();
    end
    hz.mem_ready_m = 1'b1;
    look();
    chk("defer_flush", 32'(ctrl), 32'(7'b0000110));
    tick();
    idle();
    look();
    chk("defer_flush_cnt", 32'(hz.flush_cnt), 1);
    chk("defer_stall_cnt", 32'(hz.stall_cnt), 2);
    tick();
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 9'($urandom), 7'b0);
      v.fl[0] = ($urandom % 4) != 0;
      v.fl[2] = ($urandom % 4) == 0;
      set_in(v);
      reset = ($urandom % 300 == 0) || (m_err && $urandom % 8 == 0);
      look();
      tick();
    end
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: consecutive data-memory wait cycles before ERROR, legal range 1-255.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports rs1_d, rs2_d  input  5 each  ID-stage source registers.
REQ-005 SHALL have ports rs1_used_d, rs2_used_d  input  1 each  source operand actually read.
REQ-006 SHALL have ports rd_e, rd_m, rd_w  input  5 each  destination register in EX, MEM, WB.
REQ-007 SHALL have ports regwrite_e, regwrite_m, regwrite_w  input  1 each  stage writes rd.
REQ-008 SHALL have port memread_e  input  1  EX instruction is a load.
REQ-009 SHALL have port redirect_e  input  1  taken branch or jump resolved in EX.
REQ-010 SHALL have ports mem_req_m, mem_ready_m  input  1 each  MEM-stage data-memory request and completion.
REQ-011 SHALL have ports stall_f, stall_d, stall_e, stall_m  output  1 each  hold PC, IF/ID, ID/EX, EX/MEM registers.
REQ-012 SHALL have ports flush_d, flush_e, flush_w  output  1 each  bubble into IF/ID, ID/EX, MEM/WB.
REQ-013 SHALL have port mem_timeout  output  1  sticky memory-timeout error.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-015 SHALL treat a source operand as hazarded only when rsX_used_d=1, the producer's regwrite=1, its rd matches, and rd is nonzero.
REQ-016 SHALL compute mem_stall = mem_req_m & ~mem_ready_m combinationally; all stall/flush outputs are combinational on current inputs and state.
REQ-017 SHALL apply priority ERROR > mem_stall > redirect_e > data hazard.
REQ-018 SHALL, on mem_stall, assert stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0.
REQ-019 SHALL, on redirect_e without mem_stall, assert flush_d=flush_e=1 with all stalls 0, ignoring data hazards that cycle.
REQ-020 SHALL, on data hazard alone, assert stall_f=stall_d=1, flush_e=1, stall_e=stall_m=0.
REQ-021 SHALL, with no condition active, drive all stall and flush outputs 0.
REQ-022 SHALL implement states RUN, MEM_WAIT, ERROR with an 8-bit wait counter.
REQ-023 SHALL transition RUN->MEM_WAIT on mem_stall with wait counter=1; in MEM_WAIT increment the counter each further mem_stall cycle.
REQ-024 SHALL transition MEM_WAIT->RUN and clear the counter on the first edge with mem_stall=0.
REQ-025 SHALL enter ERROR when mem_stall is sampled with counter equal to MEM_TIMEOUT, i.e. after MEM_TIMEOUT+1 consecutive stall cycles.
REQ-026 SHALL, in ERROR, assert all four stalls, all flushes 0, mem_timeout=1, until reset.
REQ-027 SHALL increment stall_cnt each cycle stall_f=1 and flush_cnt each cycle flush_d=1, both saturating at 0xFFFF.
REQ-028 SHALL defer redirect_e under mem_stall; redirect takes effect the first cycle mem_stall drops, since EX is held.

Reset
REQ-029 SHALL, while reset=1, drive stalls 0, flush_d=flush_e=flush_w=1, mem_timeout=0.
REQ-030 SHALL, at a reset edge, force state RUN, wait counter 0, stall_cnt=flush_cnt=0, including mid-wait and ERROR.

Configuration
REQ-031 SHALL, with FORWARDING_EN defined, flag data hazards only against EX when memread_e=1: one-cycle load-use stall.
REQ-032 SHALL, without FORWARDING_EN, flag data hazards against EX, MEM and WB producers regardless of memread_e, stalling until the producer retires.

Verification
REQ-033 SHALL cover load-use: memread_e=1, rd_e=5, rs1_d=5, rs1_used_d=1 -> stall_f=stall_d=flush_e=1 one cycle, stall_cnt +1.
REQ-034 SHALL cover x0: rd_e=0, rs1_d=0, memread_e=1 -> no stall or flush.
REQ-035 SHALL cover memory wait: mem_req_m=1, mem_ready_m=0 for 3 cycles then 1 -> four stalls and flush_w high 3 cycles, state back to RUN.
REQ-036 SHALL cover simultaneous events: mem_stall with redirect_e=1 for 2 cycles -> no flush until mem_ready_m=1, then flush_d=flush_e=1 one cycle, flush_cnt=1.
REQ-037 SHALL cover timeout: MEM_TIMEOUT=4, mem_ready_m=0 held -> ERROR, mem_timeout=1 from cycle 6; reset clears all outputs and counters.
REQ-038 SHALL cover without FORWARDING_EN: regwrite_m=1, rd_m=7, rs2_d=7, rs2_used_d=1, memread_e=0 -> stall_f=stall_d=flush_e=1.
